// File: rtl/cwait_merge_n_sync_if.sv
// Handshake bundle for the N-channel wait-merge barrier.
// The master side issues masks, drives and acknowledges; the slave side is the barrier.
interface cwait_merge_n_sync_if #(
  parameter int NCH  = 8,
  parameter int TO_W = 16
);
  logic [NCH-1:0]  i_mask;
  logic [NCH-1:0]  i_drive;
  logic [NCH-1:0]  o_free;
  logic            o_drive_next;
  logic            i_free_next;
  logic [TO_W-1:0] i_timeout;
  logic            o_timeout;
  logic            o_dup;
  logic [NCH-1:0]  o_arrived;
  logic            o_busy;

  modport master (
    output i_mask, i_drive, i_free_next, i_timeout,
    input  o_free, o_drive_next, o_timeout, o_dup, o_arrived, o_busy
  );

  modport slave (
    input  i_mask, i_drive, i_free_next, i_timeout,
    output o_free, o_drive_next, o_timeout, o_dup, o_arrived, o_busy
  );
endinterface

// File: rtl/cwait_merge_n_sync.sv
// N-channel join barrier: collects one drive per masked channel, raises a merged
// request, and releases every participant together on the downstream acknowledge.
module cwait_merge_n_sync #(
  parameter int NCH  = 8,
  parameter int TO_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cwait_merge_n_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2
  } state_e;

  state_e          state_q;
  logic [NCH-1:0]  r_mask_q;
  logic [NCH-1:0]  arrived_q;
  logic [NCH-1:0]  free_q;
  logic [TO_W-1:0] cnt_q;
  logic            drive_next_q;
  logic            timeout_q;
  logic            dup_q;
  logic            busy_q;

  logic            in_collect;
  logic            in_fire;
  logic [NCH-1:0]  eff_mask;
  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  dup_bits;
  logic [NCH-1:0]  merged;
  logic [TO_W:0]   cnt_inc;
  logic [TO_W-1:0] cnt_sat;
  logic            to_hit;

  assign in_collect = (state_q == ST_COLLECT);
  assign in_fire    = (state_q == ST_FIRE);

  // A new round is gated by the live mask; an open round only by the latched one.
  assign eff_mask = (state_q == ST_IDLE) ? bus.i_mask : r_mask_q;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign hit[gi]      = bus.i_drive[gi] & eff_mask[gi];
      assign dup_bits[gi] = bus.i_drive[gi] & r_mask_q[gi]
                            & (in_fire | (in_collect & arrived_q[gi]));
    end
  endgenerate

  assign merged = arrived_q | hit;

  // Unsaturated increment: once the counter pins at all-ones it can never match a limit.
  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[TO_W-1:0];
  assign to_hit  = (bus.i_timeout != '0) && (cnt_inc == {1'b0, bus.i_timeout});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      r_mask_q     <= '0;
      arrived_q    <= '0;
      free_q       <= '0;
      cnt_q        <= '0;
      drive_next_q <= 1'b0;
      timeout_q    <= 1'b0;
      dup_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      free_q    <= '0;
      timeout_q <= 1'b0;
      dup_q     <= |dup_bits;
      case (state_q)
        ST_IDLE: begin
          if (|hit) begin
            r_mask_q  <= bus.i_mask;
            arrived_q <= hit;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (hit == bus.i_mask) begin
              state_q      <= ST_FIRE;
              drive_next_q <= 1'b1;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          cnt_q <= cnt_sat;
          // Completion has priority over a timeout landing in the same cycle.
          if (merged == r_mask_q) begin
            arrived_q    <= merged;
            state_q      <= ST_FIRE;
            drive_next_q <= 1'b1;
          end else if (to_hit) begin
            free_q    <= merged;
            timeout_q <= 1'b1;
            arrived_q <= '0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            arrived_q <= merged;
          end
        end
        ST_FIRE: begin
          if (bus.i_free_next) begin
            free_q       <= r_mask_q;
            arrived_q    <= '0;
            drive_next_q <= 1'b0;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          arrived_q    <= '0;
          drive_next_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_free       = free_q;
  assign bus.o_drive_next = drive_next_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_dup        = dup_q;
  assign bus.o_arrived    = arrived_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_cwait_merge_n_sync.sv
// Scoreboard bench for the wait-merge barrier: a round-level reference model queues the
// expected outputs per cycle and the events they imply; a negedge monitor pops and compares.
module tb_cwait_merge_n_sync;
  localparam int NCH  = 8;
  localparam int TO_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cwait_merge_n_sync_if #(.NCH(NCH), .TO_W(TO_W)) bus ();

  cwait_merge_n_sync #(.NCH(NCH), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             idx;
    logic [NCH-1:0] arr;
    logic           busy;
    logic           dn;
    logic [NCH-1:0] fr;
    logic           tmo;
    logic           dup;
  } status_t;

  // kind: 0 = dup pulse, 1 = merged request rises, 2 = release, 3 = timeout abort
  typedef struct {
    int             idx;
    int             kind;
    logic [NCH-1:0] val;
  } event_t;

  status_t sq[$];
  event_t  eq[$];

  int checks_total  = 0;
  int checks_passed = 0;
  bit mon_en        = 1'b0;
  bit prev_dn       = 1'b0;

  // Reference model: phase 0 = no round open, 1 = gathering, 2 = waiting for downstream
  int              m_phase = 0;
  logic [NCH-1:0]  m_rmask = '0;
  logic [NCH-1:0]  m_arr   = '0;
  int              m_ncol  = 0;
  int              step_idx = 0;
  logic [NCH-1:0]  cur_mask = '0;
  logic [TO_W-1:0] cur_to   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_evt(input int kind, input logic [NCH-1:0] val);
    event_t e;
    e.idx = step_idx; e.kind = kind; e.val = val;
    eq.push_back(e);
  endtask

  task automatic step(input logic [NCH-1:0] drv, input logic fn);
    status_t        s;
    logic [NCH-1:0] hit;
    logic           e_dup, e_rise, e_tmo;
    logic [NCH-1:0] e_free;
    bus.i_drive     = drv;
    bus.i_free_next = fn;
    bus.i_mask      = cur_mask;
    bus.i_timeout   = cur_to;
    e_dup = 1'b0; e_rise = 1'b0; e_tmo = 1'b0; e_free = '0;
    if (m_phase == 0) begin
      hit = drv & cur_mask;
      if (hit != '0) begin
        m_rmask = cur_mask;
        m_arr   = hit;
        m_ncol  = 0;
        if (hit == cur_mask) begin m_phase = 2; e_rise = 1'b1; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if ((drv & m_rmask & m_arr) != '0) e_dup = 1'b1;
      m_arr  = m_arr | (drv & m_rmask);
      m_ncol = m_ncol + 1;
      if (m_arr == m_rmask) begin
        m_phase = 2; e_rise = 1'b1;
      end else if (cur_to != '0 && m_ncol == int'(cur_to)) begin
        e_free = m_arr; e_tmo = 1'b1; m_arr = '0; m_phase = 0;
      end
    end else begin
      if ((drv & m_rmask) != '0) e_dup = 1'b1;
      if (fn) begin e_free = m_rmask; m_arr = '0; m_phase = 0; end
    end
    s.idx = step_idx; s.arr = m_arr; s.busy = (m_phase != 0); s.dn = (m_phase == 2);
    s.fr = e_free; s.tmo = e_tmo; s.dup = e_dup;
    sq.push_back(s);
    if (e_dup)        push_evt(0, '0);
    if (e_rise)       push_evt(1, '0);
    if (e_free != '0) push_evt(2, e_free);
    if (e_tmo)        push_evt(3, '0);
    step_idx++;
    @(posedge clk);
    #1;
    bus.i_drive     = '0;
    bus.i_free_next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".free"},     32'(bus.o_free),       32'd0);
    check({tag, ".drv_next"}, 32'(bus.o_drive_next), 32'd0);
    check({tag, ".timeout"},  32'(bus.o_timeout),    32'd0);
    check({tag, ".dup"},      32'(bus.o_dup),        32'd0);
    check({tag, ".arrived"},  32'(bus.o_arrived),    32'd0);
    check({tag, ".busy"},     32'(bus.o_busy),       32'd0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    rst     = 1'b0;
    m_phase = 0;
    m_arr   = '0;
    prev_dn = 1'b0;
    $display("reset pulse at t=%0t", $time);
  endtask

  task automatic pop_evt(input int kind, input logic [NCH-1:0] val, input int idx);
    event_t e;
    checks_total++;
    if (eq.size() == 0) begin
      $display("FAIL evt_unexpected: got kind %0d val %h at cycle %0d, expected none", kind, val, idx);
      return;
    end
    checks_passed++;
    e = eq.pop_front();
    $display("event cycle=%0d kind=%0d val=%h (expected cycle=%0d kind=%0d val=%h)",
             idx, kind, val, e.idx, e.kind, e.val);
    check("evt_kind",  32'(kind), 32'(e.kind));
    check("evt_cycle", 32'(idx),  32'(e.idx));
    check("evt_val",   32'(val),  32'(e.val));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      status_t s;
      if (sq.size() == 0) begin
        checks_total++;
        $display("FAIL status_queue: got empty expected an entry (t=%0t)", $time);
      end else begin
        s = sq.pop_front();
        check("arrived",  32'(bus.o_arrived),    32'(s.arr));
        check("busy",     32'(bus.o_busy),       32'(s.busy));
        check("drv_next", 32'(bus.o_drive_next), 32'(s.dn));
        check("free",     32'(bus.o_free),       32'(s.fr));
        check("timeout",  32'(bus.o_timeout),    32'(s.tmo));
        check("dup",      32'(bus.o_dup),        32'(s.dup));
        if (bus.o_dup)                     pop_evt(0, '0, s.idx);
        if (bus.o_drive_next && !prev_dn)  pop_evt(1, '0, s.idx);
        if (bus.o_free != '0)              pop_evt(2, bus.o_free, s.idx);
        if (bus.o_timeout)                 pop_evt(3, '0, s.idx);
        prev_dn = bus.o_drive_next;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] drv;
    logic           fn;
    bus.i_mask = '0; bus.i_drive = '0; bus.i_free_next = 1'b0; bus.i_timeout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // T1: full mask, one channel per cycle, release three cycles after the request
    cur_mask = 8'hFF; cur_to = '0;
    for (int i = 0; i < NCH; i++) step(NCH'(1) << i, 1'b0);
    idle(2);
    step('0, 1'b1);
    idle(2);

    // T2: sparse mask completes in one cycle; a channel outside the mask is ignored
    cur_mask = 8'h05;
    step(8'h05, 1'b0);
    step(8'h02, 1'b0);
    step('0, 1'b1);
    idle(1);

    // T3: duplicate drive on ch3 during collection
    cur_mask = 8'hFF;
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    for (int i = 0; i < NCH; i++) if (i != 3) step(NCH'(1) << i, 1'b0);
    step('0, 1'b1);
    idle(1);

    // T4: timeout abort with only ch0 and ch1 present
    cur_to = 16'd10;
    step(8'h01, 1'b0);
    step(8'h02, 1'b0);
    idle(12);
    cur_to = '0;

    // T5: reset while the merged request is up, then a fresh round
    cur_mask = 8'h01;
    step(8'h01, 1'b0);
    idle(1);
    do_reset();
    step(8'h01, 1'b0);
    step('0, 1'b1);
    idle(1);

    // T6: mask change mid-round affects only the next round
    cur_mask = 8'h0F;
    step(8'h01, 1'b0);
    cur_mask = 8'hF0;
    step(8'h02, 1'b0);
    step(8'h04, 1'b0);
    step(8'h08, 1'b0);
    step('0, 1'b1);
    step(8'hF0, 1'b0);
    step('0, 1'b1);
    idle(1);

    // Randomized traffic
    cur_mask = 8'h3C; cur_to = 16'd8;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(19) == 0) cur_mask = NCH'($urandom_range(255));
      if ($urandom_range(29) == 0) cur_to = ($urandom_range(3) == 0) ? '0 : TO_W'($urandom_range(14, 2));
      drv = '0;
      for (int b = 0; b < NCH; b++) drv[b] = ($urandom_range(5) == 0);
      fn = ($urandom_range(3) == 0);
      if ($urandom_range(249) == 0) do_reset();
      step(drv, fn);
    end
    idle(2);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("leftover_status", 32'(sq.size()), 32'd0);
    check("leftover_events", 32'(eq.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
